disp_op_issuer: RTL

DISP_OP_ISSUER -- requirements
Module: disp_op_issuer

---
 rtl/disp_pkg.sv | 44 ++++
 rtl/disp_cond_eval.sv | 31 +++
 rtl/disp_op_issuer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// Shared opcode, condition-code and FSM encodings for the disp op issuer slice.
package disp_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_CMP = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_EQ     = 3'd1,
    COND_NE     = 3'd2,
    COND_ULT    = 3'd3,
    COND_UGE    = 3'd4,
    COND_NEG    = 3'd5,
    COND_OVF    = 3'd6,
    COND_NEVER  = 3'd7
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  // Bit positions inside the packed {C,N,V,Z} flag vector.
  localparam int FLAG_C = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  function automatic logic [3:0] pack_flags(input logic c, input logic n,
                                            input logic v, input logic z);
    return {c, n, v, z};
  endfunction

endpackage

// File: rtl/disp_cond_eval.sv
// Combinational condition-code evaluator over captured {C,N,V,Z} flags.
// Evaluation logic is present only when DISP_COND_EVAL_EN is defined; otherwise true is 0.
module disp_cond_eval
  import disp_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       true
);

`ifdef DISP_COND_EVAL_EN
  always_comb begin
    true = 1'b0;
    case (cond_e'(cond))
      COND_ALWAYS: true = 1'b1;
      COND_EQ:     true = flags[FLAG_Z];
      COND_NE:     true = ~flags[FLAG_Z];
      COND_ULT:    true = flags[FLAG_C];
      COND_UGE:    true = ~flags[FLAG_C];
      COND_NEG:    true = flags[FLAG_N];
      COND_OVF:    true = flags[FLAG_V];
      COND_NEVER:  true = 1'b0;
    endcase
  end
`else
  logic unused_inputs;
  assign unused_inputs = ^{cond, flags};
  assign true          = 1'b0;
`endif

endmodule

// File: rtl/disp_op_issuer.sv
// Accepts one command at a time, pulses the ALU once, captures result and flags, returns a response.
// Build option: define DISP_COND_EVAL_EN to register and evaluate the command condition code.
module disp_op_issuer
  import disp_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input  logic               iClock,
  input  logic               iReset,
  input  logic               iCmdValid,
  output logic               oCmdReady,
  input  logic [2:0]         iCmdOpcode,
  input  logic [31:0]        iCmdOperand0,
  input  logic [31:0]        iCmdOperand1,
  input  logic [2:0]         iCmdCond,
  output logic               oAluEnable,
  output logic [2:0]         oAluOpcode,
  output logic [31:0]        oAluOperand0,
  output logic [31:0]        oAluOperand1,
  input  logic [31:0]        iAluResult,
  input  logic               iAluCarry,
  input  logic               iAluNegative,
  input  logic               iAluOverflow,
  input  logic               iAluZero,
  output logic               oRspValid,
  input  logic               iRspReady,
  output logic [31:0]        oRspResult,
  output logic [3:0]         oRspFlags,
  output logic               oRspCondTrue,
  output logic [COUNT_W-1:0] oIssueCount
);

  state_e               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 alu_enable_q, alu_enable_d;
  logic [2:0]           alu_opcode_q, alu_opcode_d;
  logic [31:0]          alu_operand0_q, alu_operand0_d;
  logic [31:0]          alu_operand1_q, alu_operand1_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_result_q, rsp_result_d;
  logic [3:0]           rsp_flags_q, rsp_flags_d;
  logic                 rsp_cond_true_q, rsp_cond_true_d;
  logic [COUNT_W-1:0]   issue_count_q, issue_count_d;

  logic [3:0]           alu_flags;
  logic [2:0]           eval_cond;
  logic                 cond_true_now;

  assign alu_flags = pack_flags(iAluCarry, iAluNegative, iAluOverflow, iAluZero);

`ifdef DISP_COND_EVAL_EN
  logic [2:0] cond_q, cond_d;
  assign eval_cond = cond_q;
`else
  logic unused_cmd_cond;
  assign unused_cmd_cond = ^iCmdCond;
  assign eval_cond       = COND_NEVER;
`endif

  // Evaluated against the live flags during CAPTURE so the registered outcome matches the captured flags.
  disp_cond_eval u_cond_eval (
    .cond  (eval_cond),
    .flags (alu_flags),
    .true  (cond_true_now)
  );

  always_comb begin
    state_d         = state_q;
    cmd_ready_d     = 1'b0;
    alu_enable_d    = 1'b0;
    alu_opcode_d    = alu_opcode_q;
    alu_operand0_d  = alu_operand0_q;
    alu_operand1_d  = alu_operand1_q;
    rsp_valid_d     = 1'b0;
    rsp_result_d    = rsp_result_q;
    rsp_flags_d     = rsp_flags_q;
    rsp_cond_true_d = rsp_cond_true_q;
    issue_count_d   = issue_count_q;
`ifdef DISP_COND_EVAL_EN
    cond_d          = cond_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (iCmdValid && cmd_ready_q) begin
          state_d        = ST_ISSUE;
          alu_enable_d   = 1'b1;
          alu_opcode_d   = iCmdOpcode;
          alu_operand0_d = iCmdOperand0;
          alu_operand1_d = iCmdOperand1;
`ifdef DISP_COND_EVAL_EN
          cond_d         = iCmdCond;
`endif
        end else begin
          cmd_ready_d = 1'b1;
        end
      end

      ST_ISSUE: begin
        state_d       = ST_CAPTURE;
        issue_count_d = issue_count_q + COUNT_W'(1);
      end

      ST_CAPTURE: begin
        state_d         = ST_RESP;
        rsp_valid_d     = 1'b1;
        rsp_result_d    = iAluResult;
        rsp_flags_d     = alu_flags;
        rsp_cond_true_d = cond_true_now;
      end

      // Ready is deliberately withheld in the completing cycle; it rises with the following IDLE.
      ST_RESP: begin
        if (iRspReady) begin
          state_d     = ST_IDLE;
          cmd_ready_d = 1'b1;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q         <= ST_IDLE;
      cmd_ready_q     <= 1'b0;
      alu_enable_q    <= 1'b0;
      alu_opcode_q    <= '0;
      alu_operand0_q  <= '0;
      alu_operand1_q  <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_result_q    <= '0;
      rsp_flags_q     <= '0;
      rsp_cond_true_q <= 1'b0;
      issue_count_q   <= '0;
`ifdef DISP_COND_EVAL_EN
      cond_q          <= '0;
`endif
    end else begin
      state_q         <= state_d;
      cmd_ready_q     <= cmd_ready_d;
      alu_enable_q    <= alu_enable_d;
      alu_opcode_q    <= alu_opcode_d;
      alu_operand0_q  <= alu_operand0_d;
      alu_operand1_q  <= alu_operand1_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_result_q    <= rsp_result_d;
      rsp_flags_q     <= rsp_flags_d;
      rsp_cond_true_q <= rsp_cond_true_d;
      issue_count_q   <= issue_count_d;
`ifdef DISP_COND_EVAL_EN
      cond_q          <= cond_d;
`endif
    end
  end

  assign oCmdReady    = cmd_ready_q;
  assign oAluEnable   = alu_enable_q;
  assign oAluOpcode   = alu_opcode_q;
  assign oAluOperand0 = alu_operand0_q;
  assign oAluOperand1 = alu_operand1_q;
  assign oRspValid    = rsp_valid_q;
  assign oRspResult   = rsp_result_q;
  assign oRspFlags    = rsp_flags_q;
  assign oRspCondTrue = rsp_cond_true_q;
  assign oIssueCount  = issue_count_q;

endmodule
